// File: rtl/bin_to_bcd_digits.sv
// Iterative double-dabble converter: unsigned binary to four BCD digits plus a
// one-hot decimal point, with out-of-range values shown as "EEEE".
module bin_to_bcd_digits #(
  parameter int W       = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] bin_in,
  input  logic         dp_en,
  input  logic [1:0]   dp_sel,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic [3:0]   hex0,
  output logic [3:0]   hex1,
  output logic [3:0]   hex2,
  output logic [3:0]   hex3,
  output logic [3:0]   dp_out
);

  localparam int SRW = 16 + W;

  typedef enum logic [1:0] {IDLE, SHIFT, WB} state_t;

  state_t         state;
  logic [SRW-1:0] sr;
  logic [SRW-1:0] adj;
  logic [4:0]     cnt;
  logic           ovf_pend;
  logic           dp_en_q;
  logic [1:0]     dp_sel_q;

  // Add-3 correction on every BCD nibble, evaluated on the pre-shift value.
  always_comb begin
    adj = sr;
    for (int i = 0; i < 4; i++) begin
      if (sr[W+4*i +: 4] >= 4'd5)
        adj[W+4*i +: 4] = sr[W+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      dp_en_q  <= 1'b0;
      dp_sel_q <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      hex0     <= 4'h0;
      hex1     <= 4'h0;
      hex2     <= 4'h0;
      hex3     <= 4'h0;
      dp_out   <= 4'b0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr       <= {16'b0, bin_in};
            ovf_pend <= (32'(bin_in) > MAX_VAL);
            dp_en_q  <= dp_en;
            dp_sel_q <= dp_sel;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= {adj[SRW-2:0], 1'b0};
          cnt <= cnt + 5'd1;
          if (cnt == 5'(W - 1))
            state <= WB;
        end
        WB: begin
          // Overflowed values display the error code on every position.
          if (ovf_pend) begin
            hex0 <= 4'hE;
            hex1 <= 4'hE;
            hex2 <= 4'hE;
            hex3 <= 4'hE;
          end else begin
            hex0 <= sr[W    +: 4];
            hex1 <= sr[W+4  +: 4];
            hex2 <= sr[W+8  +: 4];
            hex3 <= sr[W+12 +: 4];
          end
          ovf    <= ovf_pend;
          dp_out <= dp_en_q ? (4'b0001 << dp_sel_q) : 4'b0000;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
